grepsic_feeder: RTL and testbench

Host-side byte streamer that drives the grepsic matcher's pin interface: the counterpart of the core, which consumes bytes. It accepts pattern/text bytes from an on-chip producer through a small FIFO and presents them to the matcher with a strobe/ack handshake. It watches the matcher's match line and reports the text position of each match. It is used in FPGA/bench harnesses and in self-test wrappers around the grepsic core.

---
 rtl/grepsic_feeder.sv | 179 +++++++++++++++++
 tb/tb_grepsic_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grepsic_feeder.sv
// rtl/grepsic_feeder.sv - FIFO-fed byte streamer driving the grepsic matcher strobe/ack pins
module grepsic_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_mode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  dut_data,
    output logic        dut_mode,
    output logic        dut_strobe,
    input  logic        dut_ack,
    input  logic        dut_match,
    output logic        match_valid,
    output logic [15:0] match_pos,
    output logic        timeout_err,
    output logic [15:0] text_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_WAIT_ACK, S_RELEASE, S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, empty;

    logic [7:0]  data_q, data_d;
    logic        mode_q, mode_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mv_q, mv_d;
    logic [15:0] pos_q, pos_d;
    logic [15:0] tc_q, tc_d;
    logic        err_q, err_d;

    assign in_ready = (count_q != FULL_CNT);
    assign empty    = (count_q == '0);
    assign push     = in_valid & in_ready;

    // Storage carries no reset; clearing the count is what discards old entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_mode, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!empty) state_d = S_DRIVE;
            S_DRIVE:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (dut_ack)                 state_d = S_RELEASE;
                else if (tmo_q == TMO_LAST)  state_d = S_ERROR;
            end
            S_RELEASE:  if (!dut_ack) state_d = S_IDLE;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        data_d   = data_q;
        mode_d   = mode_q;
        strobe_d = strobe_q;
        tmo_d    = tmo_q;
        mv_d     = 1'b0;
        pos_d    = pos_q;
        tc_d     = tc_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop              = 1'b1;
                    {mode_d, data_d} = mem_q[rd_ptr_q];
                end
            end
            S_DRIVE: begin
                strobe_d = 1'b1;
                tmo_d    = '0;
            end
            S_WAIT_ACK: begin
                // Ack is checked first so an ack on the final count still wins.
                if (dut_ack) begin
                    strobe_d = 1'b0;
                    if (mode_q) begin
                        if (dut_match) begin
                            mv_d  = 1'b1;
                            pos_d = tc_q;
                        end
                        tc_d = tc_q + 16'd1;
                    end else begin
                        tc_d = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    strobe_d = 1'b0;
                    data_d   = '0;
                    mode_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_ERROR: begin
                strobe_d = 1'b0;
                data_d   = '0;
                mode_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            mode_q   <= 1'b0;
            strobe_q <= 1'b0;
            tmo_q    <= '0;
            mv_q     <= 1'b0;
            pos_q    <= '0;
            tc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            strobe_q <= strobe_d;
            tmo_q    <= tmo_d;
            mv_q     <= mv_d;
            pos_q    <= pos_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    assign dut_data    = data_q;
    assign dut_mode    = mode_q;
    assign dut_strobe  = strobe_q;
    assign match_valid = mv_q;
    assign match_pos   = pos_q;
    assign timeout_err = err_q;
    assign text_count  = tc_q;

endmodule

// File: tb/tb_grepsic_feeder.sv
// tb/tb_grepsic_feeder.sv - directed and randomized checks of grepsic_feeder against a matcher-side model
module tb_grepsic_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  dut_data;
    logic        dut_mode;
    logic        dut_strobe;
    logic        dut_ack = 1'b0;
    logic        dut_match = 1'b0;
    logic        match_valid;
    logic [15:0] match_pos;
    logic        timeout_err;
    logic [15:0] text_count;

    int errors = 0;
    int checks = 0;
    int idx = 0;
    int last_pos = 0;

    typedef struct {
        logic       m;
        logic [7:0] d;
        logic       mt;
    } item_t;
    item_t q[$];

    grepsic_feeder #(.DEPTH(4), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
        .dut_data(dut_data), .dut_mode(dut_mode), .dut_strobe(dut_strobe),
        .dut_ack(dut_ack), .dut_match(dut_match),
        .match_valid(match_valid), .match_pos(match_pos),
        .timeout_err(timeout_err), .text_count(text_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic m, input logic [7:0] d);
        int n = 0;
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin step(); n++; end
        chk("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Acts as the matcher: waits for the byte, acks it, and checks the reports
    // against a running text index that restarts at each pattern byte.
    task automatic serve(input logic m, input logic [7:0] d, input logic mt,
                         input int delay, input int hold);
        int n = 0;
        logic exp_mv;
        while (!dut_strobe && n < 40) begin step(); n++; end
        chk("strobe_rise", dut_strobe, 1);
        chk("dut_data", dut_data, d);
        chk("dut_mode", dut_mode, m);
        for (int k = 0; k < delay; k++) begin
            dut_match = 1'($urandom_range(0, 1));
            step();
            chk("strobe_hold", dut_strobe, 1);
            chk("data_hold", dut_data, d);
            chk("no_early_match", match_valid, 0);
        end
        dut_ack   = 1'b1;
        dut_match = mt;
        step();
        dut_match = 1'($urandom_range(0, 1));
        exp_mv = m && mt;
        if (m) begin
            if (mt) last_pos = idx;
            idx = (idx + 1) & 16'hFFFF;
        end else begin
            idx = 0;
        end
        chk("strobe_drop", dut_strobe, 0);
        chk("match_valid", match_valid, exp_mv);
        chk("match_pos", match_pos, last_pos);
        chk("text_count", text_count, idx);
        for (int k = 1; k < hold; k++) begin
            step();
            chk("hold_no_drive", dut_strobe, 0);
            chk("hold_mv_low", match_valid, 0);
            chk("hold_count", text_count, idx);
        end
        dut_ack   = 1'b0;
        dut_match = 1'b0;
        step();
        chk("mv_one_cycle", match_valid, 0);
        chk("released", dut_strobe, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_data"}, dut_data, 0);
        chk({tag, "_mode"}, dut_mode, 0);
        chk({tag, "_strobe"}, dut_strobe, 0);
        chk({tag, "_mv"}, match_valid, 0);
        chk({tag, "_pos"}, match_pos, 0);
        chk({tag, "_err"}, timeout_err, 0);
        chk({tag, "_tc"}, text_count, 0);
    endtask

    initial begin
        int n;
        int acc;
        logic rdy;
        logic [7:0] bp [6];
        item_t it;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Basic stream: pattern 'a', then text "xaa" with matches on the last two
        push(1'b0, 8'h61);
        push(1'b1, 8'h78);
        push(1'b1, 8'h61);
        push(1'b1, 8'h61);
        serve(1'b0, 8'h61, 1'b0, 1, 1);
        serve(1'b1, 8'h78, 1'b0, 1, 1);
        serve(1'b1, 8'h61, 1'b1, 1, 1);
        chk("basic_pos1", match_pos, 1);
        serve(1'b1, 8'h61, 1'b1, 1, 1);
        chk("basic_pos2", match_pos, 2);
        chk("basic_count", text_count, 3);

        // Push-to-strobe latency from an empty FIFO
        push(1'b1, 8'h33);
        chk("lat_e0", dut_strobe, 0);
        step();
        chk("lat_e1", dut_strobe, 0);
        step();
        chk("lat_e2", dut_strobe, 1);
        serve(1'b1, 8'h33, 1'b0, 0, 1);

        // Four-phase: ack held 5 cycles with a second byte already queued
        push(1'b1, 8'hAA);
        push(1'b1, 8'hBB);
        n = idx;
        serve(1'b1, 8'hAA, 1'b1, 0, 5);
        chk("fourphase_one_inc", text_count, (n + 1) & 16'hFFFF);
        serve(1'b1, 8'hBB, 1'b0, 0, 1);

        // Pattern byte restarts the text index
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 8'h70 + 8'(k));
            serve(1'b1, 8'h70 + 8'(k), 1'b0, 0, 1);
        end
        push(1'b0, 8'h62);
        serve(1'b0, 8'h62, 1'b0, 0, 1);
        push(1'b1, 8'h62);
        serve(1'b1, 8'h62, 1'b1, 0, 1);
        chk("pattern_reset_pos", match_pos, 0);

        // Randomized batches
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                it.m  = ($urandom_range(0, 3) != 0);
                it.d  = 8'($urandom);
                it.mt = 1'($urandom_range(0, 1));
                q.push_back(it);
                push(it.m, it.d);
            end
            while (q.size() > 0) begin
                it = q.pop_front();
                serve(it.m, it.d, it.mt, $urandom_range(0, 6), $urandom_range(1, 3));
            end
        end

        // Backpressure: six back-to-back pushes with ack withheld
        for (int k = 0; k < 6; k++) bp[k] = 8'h10 + 8'(k);
        acc = 0;
        in_valid = 1'b1;
        in_mode  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = bp[acc];
            rdy = in_ready;
            chk($sformatf("bp_ready_%0d", k), rdy, (k < 5) ? 1 : 0);
            step();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_full", in_ready, 0);
        serve(1'b1, bp[0], 1'b0, 0, 1);
        push(1'b1, bp[5]);
        for (int k = 1; k < 6; k++) serve(1'b1, bp[k], 1'b0, 0, 1);

        // Ack arriving on the same cycle the counter expires is accepted
        push(1'b1, 8'hC1);
        serve(1'b1, 8'hC1, 1'b0, 9, 1);
        chk("ack10_no_err", timeout_err, 0);

        // Reset mid-WAIT_ACK with two bytes still queued
        push(1'b1, 8'h44);
        push(1'b1, 8'h55);
        push(1'b1, 8'h66);
        n = 0;
        while (!dut_strobe && n < 40) begin step(); n++; end
        chk("mid_strobe", dut_strobe, 1);
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_strobe", dut_strobe, 0);
        chk("mid_rst_ready", in_ready, 1);
        step();
        check_reset_values("mid_rst");
        rst_n = 1'b1;
        idx = 0;
        last_pos = 0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (dut_strobe) n++;
        end
        chk("discarded_never_driven", n, 0);

        // Timeout with no ack
        push(1'b1, 8'h77);
        n = 0;
        while (!dut_strobe && n < 40) begin step(); n++; end
        chk("tmo_strobe", dut_strobe, 1);
        for (int k = 1; k < 10; k++) begin
            step();
            chk("tmo_not_yet", timeout_err, 0);
        end
        step();
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_strobe_low", dut_strobe, 0);
        push(1'b1, 8'h88);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            dut_ack = (k == 3);
            step();
            if (dut_strobe) n++;
        end
        dut_ack = 1'b0;
        chk("tmo_stuck", n, 0);
        chk("tmo_sticky", timeout_err, 1);

        // Only reset leaves ERROR
        rst_n = 1'b0;
        step();
        step();
        check_reset_values("post_err_rst");
        rst_n = 1'b1;
        push(1'b1, 8'h5A);
        serve(1'b1, 8'h5A, 1'b1, 2, 1);
        chk("recover_pos", match_pos, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
